cache_req_arbiter: RTL and testbench

Round-robin front end that shares the single request port of `cache_top` between two trace requesters, e.g. instruction and data streams. Each accepted request is validated, registered and held stable on the cache port for a fixed number of clocks, so the cache datapath sees exactly one operation per slot. The block sits between the trace sources and `cache_top`, drives `cache_addr`/`cache_op`/`cache_lvl`, and keeps per-requester grant and error statistics.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/cache_req_arbiter.sv | 115 +++++++++++
 tb/tb_cache_req_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache request front end and the drivers of cache_top.
package cache_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    localparam int DEFAULT_ADDR_W = 48;
    localparam int DEFAULT_CNT_W  = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [7:0]                op;
        logic                      lvl;
    } cache_req_t;

    // Only reads and writes reach the cache; everything else is counted as an error.
    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers who was granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (advance)
            last <= grant[1];
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin front end holding one validated request per slot on the cache_top port.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [7:0]        req_op0,
    input  logic [7:0]        req_op1,
    input  logic              req_lvl0,
    input  logic              req_lvl1,
    output logic              cache_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [7:0]        cache_op,
    output logic              cache_lvl,
    output logic              cache_src,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    arb_state_t        state, state_next;
    logic [3:0]        hcnt;
    logic [1:0]        grant;
    logic              open;
    logic              hs;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_op;
    logic              sel_lvl;
    logic              op_ok;
    logic              issue;

    assign open     = (state == IDLE) || (hcnt == 4'd0);
    assign hs       = |(req_valid & req_ready);
    assign sel      = req_ready[1];
    assign sel_addr = sel ? req_addr1 : req_addr0;
    assign sel_op   = sel ? req_op1   : req_op0;
    assign sel_lvl  = sel ? req_lvl1  : req_lvl0;
    assign op_ok    = is_valid_op(sel_op);
    assign issue    = hs && op_ok;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hcnt  <= 4'd0;
        end else begin
            state <= state_next;
            if (issue)
                hcnt <= HOLD_LAST;
            else if (hcnt != 4'd0)
                hcnt <= hcnt - 4'd1;
        end
    end

    // A slot ends when the hold count reaches zero unless a new request chains on.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = issue ? ISSUE : IDLE;
            ISSUE:   if (hcnt == 4'd0) state_next = issue ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 2'b00;
        cache_valid = (state == ISSUE);
        if (!reset && open)
            req_ready = grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_addr <= '0;
            cache_op   <= 8'h00;
            cache_lvl  <= 1'b0;
            cache_src  <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (issue) begin
                cache_addr <= sel_addr;
                cache_op   <= sel_op;
                cache_lvl  <= sel_lvl;
                cache_src  <= sel;
                if (!sel && grant_cnt0 != '1)
                    grant_cnt0 <= grant_cnt0 + 1'b1;
                if (sel && grant_cnt1 != '1)
                    grant_cnt1 <= grant_cnt1 + 1'b1;
            end
            if (hs && !op_ok && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_cache_req_arbiter;

    localparam int HOLD    = 5;
    localparam int CNT_MAX = 4095;
    localparam int SAT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [47:0] req_addr0, req_addr1;
    logic [7:0]  req_op0, req_op1;
    logic        req_lvl0, req_lvl1;
    logic        cache_valid;
    logic [47:0] cache_addr;
    logic [7:0]  cache_op;
    logic        cache_lvl;
    logic        cache_src;
    logic [11:0] grant_cnt0, grant_cnt1, err_cnt;

    logic        s_reset;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic        s_cvalid;
    logic [47:0] s_caddr;
    logic [7:0]  s_cop;
    logic        s_clvl, s_csrc;
    logic [3:0]  s_g0, s_g1, s_err;

    int vectors = 0;
    int miscompares = 0;

    // Model: remaining visible cycles of the current slot, last granted requester, payload, counts.
    int          mRemain;
    int          mLast;
    logic [47:0] mAddr;
    logic [7:0]  mOp;
    logic        mLvl, mSrc;
    int          mG0, mG1, mErr;

    always #5 clk = ~clk;

    cache_req_arbiter #(.HOLD_CYCLES(HOLD), .ADDR_W(48), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_op0(req_op0), .req_op1(req_op1),
        .req_lvl0(req_lvl0), .req_lvl1(req_lvl1), .cache_valid(cache_valid),
        .cache_addr(cache_addr), .cache_op(cache_op), .cache_lvl(cache_lvl),
        .cache_src(cache_src), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
        .err_cnt(err_cnt)
    );

    cache_req_arbiter #(.HOLD_CYCLES(1), .ADDR_W(48), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(s_reset), .req_valid(s_valid), .req_ready(s_ready),
        .req_addr0(48'h0000_1234_5678), .req_addr1(48'h0), .req_op0(8'h57), .req_op1(8'h52),
        .req_lvl0(1'b1), .req_lvl1(1'b0), .cache_valid(s_cvalid),
        .cache_addr(s_caddr), .cache_op(s_cop), .cache_lvl(s_clvl),
        .cache_src(s_csrc), .grant_cnt0(s_g0), .grant_cnt1(s_g1), .err_cnt(s_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mRemain = 0;
        mLast   = 1;
        mAddr   = '0;
        mOp     = 8'h00;
        mLvl    = 1'b0;
        mSrc    = 1'b0;
        mG0     = 0;
        mG1     = 0;
        mErr    = 0;
    endfunction

    function automatic int satInc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Drive one cycle, compare everything against the model, then advance the model across the edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] v,
                                 input logic [47:0] a0, input logic [7:0] o0, input logic l0,
                                 input logic [47:0] a1, input logic [7:0] o1, input logic l1);
        int         g;
        logic [1:0] expReady;
        logic [7:0] op;
        @(negedge clk);
        reset = rst; req_valid = v;
        req_addr0 = a0; req_op0 = o0; req_lvl0 = l0;
        req_addr1 = a1; req_op1 = o1; req_lvl1 = l1;
        #1;
        if (v == 2'b01)      g = 0;
        else if (v == 2'b10) g = 1;
        else if (v == 2'b11) g = (mLast == 0) ? 1 : 0;
        else                 g = -1;
        expReady = 2'b00;
        if (!rst && mRemain <= 1 && g >= 0) expReady = (g == 0) ? 2'b01 : 2'b10;
        checkOutput("req_ready",   64'(req_ready),   64'(expReady));
        checkOutput("cache_valid", 64'(cache_valid), 64'(mRemain > 0));
        checkOutput("cache_addr",  64'(cache_addr),  64'(mAddr));
        checkOutput("cache_op",    64'(cache_op),    64'(mOp));
        checkOutput("cache_lvl",   64'(cache_lvl),   64'(mLvl));
        checkOutput("cache_src",   64'(cache_src),   64'(mSrc));
        checkOutput("grant_cnt0",  64'(grant_cnt0),  64'(mG0));
        checkOutput("grant_cnt1",  64'(grant_cnt1),  64'(mG1));
        checkOutput("err_cnt",     64'(err_cnt),     64'(mErr));
        if (rst) begin
            modelReset();
        end else if (expReady != 2'b00) begin
            op = (g == 1) ? o1 : o0;
            mLast = g;
            if (op == 8'h52 || op == 8'h57) begin
                mRemain = HOLD;
                mAddr   = (g == 1) ? a1 : a0;
                mOp     = op;
                mLvl    = (g == 1) ? l1 : l0;
                mSrc    = (g == 1);
                if (g == 0) mG0 = satInc(mG0, CNT_MAX);
                else        mG1 = satInc(mG1, CNT_MAX);
            end else begin
                mErr = satInc(mErr, CNT_MAX);
                if (mRemain > 0) mRemain--;
            end
        end else if (mRemain > 0) begin
            mRemain--;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 2'b00, 48'h0, 8'h00, 1'b0, 48'h0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0]  ops [4];
        logic [47:0] ra0, ra1;
        logic [7:0]  ro0, ro1;
        ops[0] = 8'h52; ops[1] = 8'h57; ops[2] = 8'h41; ops[3] = 8'h57;

        reset = 1'b1; req_valid = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_op0 = '0; req_op1 = '0; req_lvl0 = 0; req_lvl1 = 0;
        s_reset = 1'b1; s_valid = 2'b00;
        repeat (2) @(posedge clk);
        modelReset();

        // Reset values, then idle after release
        applyStimulus(1'b1, 2'b11, 48'h1, 8'h52, 1'b1, 48'h2, 8'h57, 1'b1);
        idleCycles(3);

        // Single write from requester 0, held for the full slot
        applyStimulus(1'b0, 2'b01, 48'h7fff493822b8, 8'h57, 1'b0, 48'h0, 8'h00, 1'b0);
        idleCycles(HOLD + 1);
        checkOutput("single_grant_cnt0", 64'(grant_cnt0), 64'd1);

        // Illegal op from requester 1 is consumed without issuing
        applyStimulus(1'b0, 2'b10, 48'h0, 8'h00, 1'b0, 48'h123, 8'h41, 1'b1);
        idleCycles(2);
        checkOutput("err_cnt_after_bad_op", 64'(err_cnt), 64'd1);

        // Both requesters held valid across four back-to-back slots
        applyStimulus(1'b1, 2'b00, 48'h0, 8'h00, 1'b0, 48'h0, 8'h00, 1'b0);
        for (int i = 0; i < 4 * HOLD; i++)
            applyStimulus(1'b0, 2'b11, 48'haaaa_0000 + 48'(i), 8'h52, 1'b0,
                          48'hbbbb_0000 + 48'(i), 8'h57, 1'b1);
        idleCycles(1);
        checkOutput("rr_grant_cnt0", 64'(grant_cnt0), 64'd2);
        checkOutput("rr_grant_cnt1", 64'(grant_cnt1), 64'd2);
        idleCycles(HOLD);

        // Reset mid-slot, then a tie goes to requester 0
        applyStimulus(1'b0, 2'b10, 48'h0, 8'h00, 1'b0, 48'h5555, 8'h52, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 2'b00, 48'h0, 8'h00, 1'b0, 48'h0, 8'h00, 1'b0);
        applyStimulus(1'b0, 2'b11, 48'h77, 8'h57, 1'b1, 48'h88, 8'h52, 1'b0);
        idleCycles(1);
        checkOutput("tie_after_reset_src", 64'(cache_src), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ra0 = {16'($urandom), $urandom};
            ra1 = {16'($urandom), $urandom};
            ro0 = ops[$urandom_range(3)];
            ro1 = ops[$urandom_range(3)];
            applyStimulus(($urandom_range(59) == 0), 2'($urandom), ra0, ro0, 1'($urandom),
                          ra1, ro1, 1'($urandom));
        end

        // Saturation on the HOLD_CYCLES=1 / CNT_W=4 instance
        @(negedge clk);
        s_reset = 1'b0; s_valid = 2'b01;
        for (int n = 1; n <= 20; n++) begin
            #1;
            checkOutput("sat_req_ready", 64'(s_ready), 64'(2'b01));
            @(negedge clk);
            #1;
            checkOutput("sat_grant_cnt0", 64'(s_g0), 64'((n < SAT_MAX) ? n : SAT_MAX));
            checkOutput("sat_cache_valid", 64'(s_cvalid), 64'd1);
        end
        s_valid = 2'b00;
        @(negedge clk);
        #1;
        checkOutput("sat_idle_valid", 64'(s_cvalid), 64'd0);
        checkOutput("sat_final_cnt0", 64'(s_g0), 64'(SAT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
